// File: rtl/button_incr_pkg.sv
// Shared types for the push-button increment front end: FSM state encoding
// and a helper used to size the shared interval timer.
package button_incr_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESS_WAIT   = 3'd1,
        PRESSED      = 3'd2,
        REPEAT       = 3'd3,
        RELEASE_WAIT = 3'd4
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous bit; q is the last stage.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_ff: STAGES must be >= 2");
    end

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/button_incr_gen.sv
// Push-button front end for counter.incr: synchronise, debounce, one pulse per
// accepted press, optional hold-to-repeat. All outputs are registered.
module button_incr_gen
    import button_incr_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8,
    parameter int REPEAT_CYCLES   = 3,
    parameter int REPEAT_EN       = 1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   btn_in,
    output logic   incr,
    output logic   btn_level,
    output logic   repeating,
    output state_t state
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("button_incr_gen: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("button_incr_gen: DEBOUNCE_CYCLES must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("button_incr_gen: HOLD_CYCLES must be >= 1");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("button_incr_gen: REPEAT_CYCLES must be >= 1");
    end
    if (REPEAT_EN != 0 && REPEAT_EN != 1) begin : g_bad_repeat_en
        $error("button_incr_gen: REPEAT_EN must be 0 or 1");
    end

    localparam int TIMER_W = $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)) + 1;

    localparam logic [TIMER_W-1:0] DEB_LAST  = TIMER_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] REP_LAST  = TIMER_W'(REPEAT_CYCLES - 1);
    localparam logic               RPT_ON    = (REPEAT_EN != 0);

    logic               btn_s;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_inc;
    logic [TIMER_W-1:0] timer_nxt;
    state_t             state_nxt;
    logic               pulse_nxt;
    logic               level_nxt;
    logic               repeating_nxt;

    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (btn_in),
        .q  (btn_s)
    );

    // Saturating increment: with repeat disabled the timer idles at all-ones in PRESSED.
    assign timer_inc = (timer == {TIMER_W{1'b1}}) ? timer : timer + TIMER_W'(1);

    // A btn_s change is tested before any terminal count, so it always wins.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer_inc;
        pulse_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                timer_nxt = '0;
                if (btn_s) begin
                    state_nxt = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end else if (timer == DEB_LAST) begin
                    state_nxt = PRESSED;
                    timer_nxt = '0;
                    pulse_nxt = 1'b1;
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_nxt = RELEASE_WAIT;
                    timer_nxt = '0;
                end else if (RPT_ON && timer == HOLD_LAST) begin
                    state_nxt = REPEAT;
                    timer_nxt = '0;
                    pulse_nxt = 1'b1;
                end
            end
            REPEAT: begin
                if (!btn_s) begin
                    state_nxt = RELEASE_WAIT;
                    timer_nxt = '0;
                end else if (timer == REP_LAST) begin
                    timer_nxt = '0;
                    pulse_nxt = 1'b1;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    // Release bounce: back to PRESSED, hold interval starts over.
                    state_nxt = PRESSED;
                    timer_nxt = '0;
                end else if (timer == DEB_LAST) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    assign level_nxt     = (state_nxt == PRESSED) || (state_nxt == REPEAT) ||
                           (state_nxt == RELEASE_WAIT);
    assign repeating_nxt = (state_nxt == REPEAT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            incr      <= 1'b0;
            btn_level <= 1'b0;
            repeating <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            incr      <= pulse_nxt;
            btn_level <= level_nxt;
            repeating <= repeating_nxt;
        end
    end

endmodule
